// File: rtl/arc4_encrypt.sv
// ARC4 stream encryptor: PRGA over a key-scheduled S memory, plaintext in, ciphertext out.
// Optional keystream tap enabled by defining ARC4_KEYSTREAM_OUT_EN.
module arc4_encrypt #(
  parameter int MSG_AW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              rdy,
  output logic [7:0]        s_addr,
  input  logic [7:0]        s_rddata,
  output logic [7:0]        s_wrdata,
  output logic              s_wren,
  output logic [MSG_AW-1:0] pt_addr,
  input  logic [7:0]        pt_rddata,
  output logic [MSG_AW-1:0] ct_addr,
  output logic [7:0]        ct_wrdata,
  output logic              ct_wren
`ifdef ARC4_KEYSTREAM_OUT_EN
  ,
  output logic [7:0]        ks_byte,
  output logic              ks_valid
`endif
);

  typedef enum logic [3:0] {
    IDLE, RD_LEN, LEN, RD_SI, RD_SJ, WR_SI, WR_SJ, RD_PAD, WR_CT
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] i, j, k, len, si, sj;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = RD_LEN;
      RD_LEN:  state_nxt = LEN;
      LEN:     state_nxt = (pt_rddata == 8'd0) ? IDLE : RD_SI;
      RD_SI:   state_nxt = RD_SJ;
      RD_SJ:   state_nxt = WR_SI;
      WR_SI:   state_nxt = WR_SJ;
      WR_SJ:   state_nxt = RD_PAD;
      RD_PAD:  state_nxt = WR_CT;
      WR_CT:   state_nxt = (k == len) ? IDLE : RD_SI;
      default: state_nxt = IDLE;
    endcase
  end

  // PRGA index registers; i/j restart every message while S keeps its permutation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i   <= '0;
      j   <= '0;
      k   <= '0;
      len <= '0;
      si  <= '0;
      sj  <= '0;
    end else begin
      case (state)
        LEN: begin
          len <= pt_rddata;
          i   <= '0;
          j   <= '0;
          k   <= 8'd1;
        end
        RD_SI: i <= i + 8'd1;
        RD_SJ: begin
          si <= s_rddata;
          j  <= j + s_rddata;
        end
        WR_SI: sj <= s_rddata;
        WR_CT: if (k != len) k <= k + 8'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    rdy       = 1'b0;
    s_addr    = '0;
    s_wrdata  = '0;
    s_wren    = 1'b0;
    pt_addr   = '0;
    ct_addr   = '0;
    ct_wrdata = '0;
    ct_wren   = 1'b0;
    case (state)
      IDLE:  rdy = 1'b1;
      LEN: begin
        ct_wrdata = pt_rddata;
        ct_wren   = 1'b1;
      end
      RD_SI: s_addr = i + 8'd1;
      // s_rddata holds S[i] here, so the new j is formed without waiting a cycle
      RD_SJ: s_addr = j + s_rddata;
      WR_SI: begin
        s_addr   = i;
        s_wrdata = s_rddata;
        s_wren   = 1'b1;
      end
      WR_SJ: begin
        s_addr   = j;
        s_wrdata = si;
        s_wren   = 1'b1;
      end
      RD_PAD: begin
        s_addr  = si + sj;
        pt_addr = MSG_AW'(k);
      end
      WR_CT: begin
        ct_addr   = MSG_AW'(k);
        ct_wrdata = s_rddata ^ pt_rddata;
        ct_wren   = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef ARC4_KEYSTREAM_OUT_EN
  always_comb begin
    ks_valid = (state == WR_CT);
    ks_byte  = (state == WR_CT) ? s_rddata : 8'd0;
  end
`endif

endmodule

// File: tb/tb_arc4_encrypt.sv
// Scoreboarded bench for arc4_encrypt: reference ARC4 model predicts every ciphertext write.
module tb_arc4_encrypt;
  logic       clk = 1'b0;
  logic       rst, en, rdy;
  logic [7:0] s_addr, s_rddata, s_wrdata, pt_addr, pt_rddata, ct_addr, ct_wrdata;
  logic       s_wren, ct_wren;
`ifdef ARC4_KEYSTREAM_OUT_EN
  logic [7:0] ks_byte;
  logic       ks_valid;
`endif

  arc4_encrypt #(.MSG_AW(8)) dut (
    .clk(clk), .rst(rst), .en(en), .rdy(rdy),
    .s_addr(s_addr), .s_rddata(s_rddata), .s_wrdata(s_wrdata), .s_wren(s_wren),
    .pt_addr(pt_addr), .pt_rddata(pt_rddata),
    .ct_addr(ct_addr), .ct_wrdata(ct_wrdata), .ct_wren(ct_wren)
`ifdef ARC4_KEYSTREAM_OUT_EN
    , .ks_byte(ks_byte), .ks_valid(ks_valid)
`endif
  );

  always #5 clk = ~clk;

  logic [7:0]  s_mem [256];
  logic [7:0]  s_init[256];
  logic [7:0]  ms    [256];
  logic [7:0]  pt_mem[256];
  logic [7:0]  ct_mem[256];
  logic        load_s = 1'b0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_e;
  int          checks = 0, passes = 0;
  int          s_wcnt = 0, ct_wcnt = 0, acc_cnt = 0;

  // synchronous single-port memories, 1-cycle read latency
  always @(posedge clk) begin
    if (load_s) s_mem <= s_init;
    else begin
      s_rddata <= s_mem[s_addr];
      if (s_wren) begin
        s_mem[s_addr] <= s_wrdata;
        s_wcnt <= s_wcnt + 1;
      end
    end
    pt_rddata <= pt_mem[pt_addr];
    if (ct_wren) begin
      ct_mem[ct_addr] <= ct_wrdata;
      ct_wcnt <= ct_wcnt + 1;
    end
    if (!rst && en && rdy) acc_cnt <= acc_cnt + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (!rst && ct_wren) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL ct_write unexpected addr=%0d data=%0h expected=none", ct_addr, ct_wrdata);
      end else begin
        exp_e = exp_q.pop_front();
        chk("ct_write", {ct_addr, ct_wrdata}, exp_e);
      end
    end
`ifdef ARC4_KEYSTREAM_OUT_EN
    if (!rst && ks_valid) chk("ks_byte", ks_byte, ct_wrdata ^ pt_rddata);
`endif
  end

  // Reference: plain ARC4 PRGA on the model S copy, i/j restarting at 0
  task automatic model(input int n);
    int ii = 0, jj = 0, a, b;
    logic [7:0] t;
    exp_q.push_back({8'h00, 8'(n)});
    for (int kk = 1; kk <= n; kk++) begin
      ii = (ii + 1) % 256;
      jj = (jj + int'(ms[ii])) % 256;
      t = ms[ii]; ms[ii] = ms[jj]; ms[jj] = t;
      a = ms[ii]; b = ms[jj];
      exp_q.push_back({8'(kk), pt_mem[kk] ^ ms[(a + b) % 256]});
    end
  endtask

  task automatic load_mem();
    ms = s_init;
    load_s = 1'b1;
    @(posedge clk); #1;
    load_s = 1'b0;
  endtask

  task automatic ident();
    for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
  endtask

  task automatic rand_perm();
    int r;
    logic [7:0] t;
    ident();
    for (int x = 255; x > 0; x--) begin
      r = $urandom_range(x, 0);
      t = s_init[x]; s_init[x] = s_init[r]; s_init[r] = t;
    end
  endtask

  task automatic rand_pt(input int n);
    pt_mem[0] = 8'(n);
    for (int x = 1; x <= n; x++) pt_mem[x] = 8'($urandom);
  endtask

  function automatic int s_diff();
    int d = 0;
    for (int x = 0; x < 256; x++) if (s_mem[x] !== ms[x]) d++;
    return d;
  endfunction

  task automatic run(input int n, output int lat);
    model(n);
    en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    lat = 0;
    while (!rdy && lat < 3000) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("drained", exp_q.size(), 0);
    chk("s_state", s_diff(), 0);
  endtask

  logic [7:0] ref_ct[9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
  string key = "Key", ptxt = "Plaintext";

  initial begin
    int lat, sw0, cw0, base, cyc, jj, len;
    logic [7:0] t;
    rst = 1'b1; en = 1'b0;
    for (int x = 0; x < 256; x++) begin pt_mem[x] = '0; s_init[x] = '0; end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rdy", rdy, 1);
    chk("reset_outs", {s_addr, s_wrdata, s_wren, pt_addr, ct_addr, ct_wrdata, ct_wren}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // single zero byte over identity S
    ident(); load_mem();
    pt_mem[0] = 8'd1; pt_mem[1] = 8'h00;
    run(1, lat);
    chk("lat_len1", lat, 8);
    chk("ct1_len1", ct_mem[1], 8'h02);
    chk("s_ident_kept", s_mem[2], 8'h02);

    ident(); load_mem();
    pt_mem[0] = 8'd2; pt_mem[1] = 8'h00; pt_mem[2] = 8'h00;
    run(2, lat);
    chk("ct2_len2", ct_mem[2], 8'h05);
    chk("s2_after", s_mem[2], 8'h03);
    chk("s3_after", s_mem[3], 8'h02);

    // known vector: KSA("Key") then "Plaintext"
    ident(); jj = 0;
    for (int x = 0; x < 256; x++) begin
      jj = (jj + int'(s_init[x]) + int'(key[x % 3])) % 256;
      t = s_init[x]; s_init[x] = s_init[jj]; s_init[jj] = t;
    end
    load_mem();
    pt_mem[0] = 8'd9;
    for (int x = 0; x < 9; x++) pt_mem[x+1] = ptxt[x];
    run(9, lat);
    chk("lat_len9", lat, 56);
    for (int x = 0; x < 9; x++) chk("ct_key_vec", ct_mem[x+1], ref_ct[x]);

    // empty message
    pt_mem[0] = 8'd0;
    sw0 = s_wcnt; cw0 = ct_wcnt;
    run(0, lat);
    chk("lat_len0", lat, 2);
    chk("len0_s_writes", s_wcnt - sw0, 0);
    chk("len0_ct_writes", ct_wcnt - cw0, 1);
    chk("len0_ct0", ct_mem[0], 8'h00);

    // reset during the fourth byte of a 9-byte message
    ident(); load_mem(); rand_pt(9);
    model(9);
    en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    repeat (21) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("abort_rdy", rdy, 1);
    chk("abort_outs", {s_addr, s_wrdata, s_wren, pt_addr, ct_addr, ct_wrdata, ct_wren}, 0);
    chk("abort_pending", exp_q.size(), 6);
    exp_q.delete();
    sw0 = s_wcnt; cw0 = ct_wcnt;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("abort_no_s_wr", s_wcnt - sw0, 0);
    chk("abort_no_ct_wr", ct_wcnt - cw0, 0);
    ident(); load_mem(); rand_pt(7);
    run(7, lat);
    chk("lat_after_abort", lat, 44);

    // en held for two back-to-back messages, toggled while busy
    rand_perm(); load_mem(); rand_pt(5);
    model(5); model(5);
    base = acc_cnt; cyc = 0;
    en = 1'b1;
    while ((acc_cnt - base < 2 || !rdy) && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      if (acc_cnt - base >= 2) en = 1'b0;
      else en = rdy ? 1'b1 : 1'($urandom);
    end
    en = 1'b0;
    @(posedge clk); #1;
    chk("b2b_accepts", acc_cnt - base, 2);
    chk("b2b_drained", exp_q.size(), 0);
    chk("b2b_s_state", s_diff(), 0);

    // random S permutations and lengths; some runs continue from the permuted S
    for (int r = 0; r < 6; r++) begin
      if (r % 2 == 0) begin rand_perm(); load_mem(); end
      len = (r == 3) ? 255 : int'($urandom_range(40, 1));
      rand_pt(len);
      run(len, lat);
      chk("lat_rand", lat, 2 + 6 * len);
    end

    chk("final_queue", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/arc4_encrypt.md
Name: arc4_encrypt

Overview:
- ARC4 stream encryptor: the writer of the length-prefixed ciphertext memory that the decryption path reads back.
- Runs the PRGA over an already key-scheduled S memory, reads a length-prefixed plaintext memory, and writes a length-prefixed ciphertext memory.
- Sits beside init/ksa under the task top level, sharing the same en/rdy start handshake and the same synchronous single-port memory interfaces.

Parameters:
- MSG_AW, 8: address width of plaintext/ciphertext memories; max message length 255 bytes regardless.

Ports:
- clk  in  1  system clock (CLOCK_50 at top level)
- rst  in  1  asynchronous reset, active-high
- en  in  1  start request, sampled only while rdy=1
- rdy  out  1  idle/ready; high when a new en is accepted
- s_addr  out  8  S memory address
- s_rddata  in  8  S memory read data, valid 1 cycle after s_addr
- s_wrdata  out  8  S memory write data
- s_wren  out  1  S memory write enable
- pt_addr  out  MSG_AW  plaintext memory address
- pt_rddata  in  8  plaintext read data, 1-cycle latency
- ct_addr  out  MSG_AW  ciphertext memory address
- ct_wrdata  out  8  ciphertext write data
- ct_wren  out  1  ciphertext write enable

Behaviour:
- Reset (async, active-high): state IDLE; rdy=1; all addresses, wrdata and wren = 0; i, j, k, len = 0. Reset mid-operation abandons the message immediately; no further writes occur.
- Memories: synchronous read. The address presented in cycle t gives data on rddata in cycle t+1.
- Handshake: en && rdy moves to RD_LEN next edge and rdy drops the same edge. en while rdy=0 is ignored. rdy returns high the cycle after the final ct write. en may be held high for back-to-back messages.
- RD_LEN: pt_addr=0.
- LEN: len=pt_rddata; ct_addr=0, ct_wrdata=len, ct_wren=1; i=j=0, k=1.
  - len=0 -> IDLE.
  - Otherwise -> RD_SI.
- Per-byte loop, 6 cycles, all arithmetic mod 256:
  - RD_SI: s_addr=i+1; register i=i+1.
  - RD_SJ: si=s_rddata; j=j+si; s_addr=j+si (combinational).
  - WR_SI: sj=s_rddata; s_addr=i, s_wrdata=sj, s_wren=1.
  - WR_SJ: s_addr=j, s_wrdata=si, s_wren=1.
  - RD_PAD: s_addr=si+sj; pt_addr=k.
  - WR_CT: ct_addr=k, ct_wrdata=s_rddata ^ pt_rddata, ct_wren=1. If k==len -> IDLE, else k=k+1 -> RD_SI.
- Total latency from en accept to rdy high: 2 + 6*len cycles.
- i==j: both swap writes hit the same address with the original value, so S is unchanged. No special case.
- i wraps 255->0 and j wraps naturally. The PRGA index i is independent of the message index k.
- wren pulses are exactly one cycle; outside write states every wren is 0.
- S contents are left permuted at completion. Re-running without re-initialising S continues the permutation from that state, but i and j restart at 0.

Optional Feature:
- ARC4_KEYSTREAM_OUT_EN defined: adds output ports ks_byte[7:0] and ks_valid. ks_valid pulses high in the WR_CT cycle with ks_byte = s_rddata (the pad byte); both reset to 0.
- Undefined: these ports do not exist and behaviour is otherwise identical.

Test Plan:
- Identity S (s[x]=x), pt = {len=1, 0x00}, pulse en -> ct[0]=0x01, ct[1]=0x02; rdy high 8 cycles after accept; S unchanged.
- Identity S, pt = {2, 0x00, 0x00} -> ct[1]=0x02, ct[2]=0x05; afterwards s[2]=0x03 and s[3]=0x02.
- S preloaded with the KSA result for key "Key", pt = {9, "Plaintext"} -> ct[1..9] = BB F3 16 E8 D9 40 AF 0A D3.
- len=0 -> only ct[0]=0x00 written, no S writes, rdy back after 2 cycles.
- Assert rst 3 byte-iterations into a 9-byte message -> all outputs 0 and rdy=1 immediately; no writes afterwards. A new en then completes correctly.
- en held high through a run and toggled while busy -> ignored until rdy. With ARC4_KEYSTREAM_OUT_EN, ks_byte equals ct ^ pt on every ks_valid.
